// File: rtl/cs_pkg.sv
// cs_pkg: shared widths and result type for the CS computational system
package cs_pkg;
  localparam int CS_DW = 10;
  localparam int CS_WIN = 9;
  typedef logic [CS_DW-1:0] cs_result_t;
endpackage

// File: rtl/cs_sync_fifo.sv
// cs_sync_fifo: single-clock FIFO; full/empty come from the level count, pointers wrap naturally
module cs_sync_fifo #(
  parameter int DW = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic wr_en, rd_en;
  assign full = level_q == LVL_FULL;
  assign empty = level_q == '0;
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;
  // next pointers and occupancy; a simultaneous push and pop leaves the level alone
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d = (wr_en & ~rd_en) ? level_q + LVL_ONE : (rd_en & ~wr_en) ? level_q - LVL_ONE : level_q;
  end
  // pointer and level registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
    end
  end
  // storage is not reset; it is only read while non-empty
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/cs_result_buffer.sv
// cs_result_buffer: drops warm-up results, buffers the rest for a valid/ready consumer; CS_RB_STATS_EN adds y_max/y_min
module cs_result_buffer
  import cs_pkg::*;
#(
  parameter int DW = CS_DW,
  parameter int DEPTH = 8,
  parameter int SKIP = CS_WIN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DW-1:0]          y_in,
  input  logic                   y_vld,
  output logic [DW-1:0]          out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
`ifdef CS_RB_STATS_EN
  ,
  output logic [DW-1:0]          y_max,
  output logic [DW-1:0]          y_min
`endif
);
  localparam int SW = $clog2(SKIP + 2);
  localparam logic [SW-1:0] SKIP_END = SW'(SKIP);
  localparam logic [SW-1:0] SKIP_ONE = SW'(1);
  logic [SW-1:0] skip_q, skip_d;
  logic overflow_q, overflow_d;
  logic skip_done, push_req, pop, full, empty;
  logic [DW-1:0] rdata;
  assign skip_done = skip_q == SKIP_END;
  assign push_req = y_vld & skip_done;
  assign pop = out_valid & out_ready;
  assign out_valid = ~empty;
  assign out_data = out_valid ? rdata : '0;
  assign overflow = overflow_q;
  cs_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push_req),
    .pop(pop),
    .wdata(y_in),
    .rdata(rdata),
    .level(level),
    .full(full),
    .empty(empty)
  );
  // warm-up counter saturates at SKIP; overflow sticks once a sample is lost to a full FIFO
  always_comb begin
    skip_d = (y_vld & ~skip_done) ? skip_q + SKIP_ONE : skip_q;
    overflow_d = overflow_q | (push_req & full & ~pop);
  end
  // control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      skip_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      skip_q <= skip_d;
      overflow_q <= overflow_d;
    end
  end
`ifdef CS_RB_STATS_EN
  logic [DW-1:0] y_max_q, y_min_q;
  assign y_max = y_max_q;
  assign y_min = y_min_q;
  // running extremes over every post-skip sample, including ones dropped on overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      y_max_q <= '0;
      y_min_q <= '1;
    end else if (push_req) begin
      y_max_q <= (y_in > y_max_q) ? y_in : y_max_q;
      y_min_q <= (y_in < y_min_q) ? y_in : y_min_q;
    end
  end
`endif
endmodule

// File: tb/tb_cs_result_buffer.sv
// tb_cs_result_buffer: scoreboard bench for cs_result_buffer; covers CS_RB_STATS_EN when defined
module tb_cs_result_buffer;
  localparam int DW = 10;
  localparam int DEPTH = 8;
  localparam int SKIP = 9;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [DW-1:0] y_in = '0;
  logic y_vld = 1'b0;
  logic out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic out_valid;
  logic [$clog2(DEPTH):0] level;
  logic overflow;
`ifdef CS_RB_STATS_EN
  logic [DW-1:0] y_max, y_min;
`endif
  int total = 0;
  int bad = 0;
  logic [DW-1:0] sb [$];
  int skip_m = 0;
  bit ovf_m = 1'b0;
  bit armed = 1'b0;
  logic [DW-1:0] max_m = '0;
  logic [DW-1:0] min_m = '1;

  cs_result_buffer #(.DW(DW), .DEPTH(DEPTH), .SKIP(SKIP)) dut (
    .clk(clk),
    .reset(reset),
    .y_in(y_in),
    .y_vld(y_vld),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level(level),
    .overflow(overflow)
`ifdef CS_RB_STATS_EN
    ,
    .y_max(y_max),
    .y_min(y_min)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // compare the DUT against the reference at negedge, then drive the next cycle and advance the reference
  task automatic cyc(input bit rst, input bit v, input logic [DW-1:0] d, input bit r);
    bit pop, preq;
    @(negedge clk);
    if (armed) begin
      chk("out_valid", out_valid, sb.size() != 0);
      chk("out_data", out_data, sb.size() != 0 ? sb[0] : '0);
      chk("level", level, sb.size());
      chk("overflow", overflow, ovf_m);
`ifdef CS_RB_STATS_EN
      chk("y_max", y_max, max_m);
      chk("y_min", y_min, min_m);
`endif
    end
    reset = rst;
    y_vld = v;
    y_in = d;
    out_ready = r;
    if (rst) begin
      sb.delete();
      skip_m = 0;
      ovf_m = 1'b0;
      max_m = '0;
      min_m = '1;
      armed = 1'b1;
    end else begin
      pop = sb.size() != 0 && r;
      preq = v && skip_m == SKIP;
      if (v && skip_m < SKIP) skip_m++;
      if (pop) void'(sb.pop_front());
      if (preq) begin
        if (d > max_m) max_m = d;
        if (d < min_m) min_m = d;
        if (sb.size() < DEPTH) sb.push_back(d);
        else ovf_m = 1'b1;
      end
    end
  endtask

  initial begin
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    // warm-up discard then streaming with consumer always ready
    for (int i = 0; i < 30; i++) cyc(0, 1, DW'(i), 1);
    // overflow: ten pushes into an eight-deep FIFO, then drain
    for (int i = 0; i < 10; i++) cyc(0, 1, DW'(100 + i), 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);
    // reset mid-stream with five entries held
    for (int i = 0; i < 5; i++) cyc(0, 1, DW'(150 + i), 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 1, DW'(400 + i), 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    // fill, then push and pop together while full
    for (int i = 0; i < 8; i++) cyc(0, 1, DW'(110 + i), 0);
    cyc(0, 1, 200, 1);
    // stall: data and level must hold
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1);
    // random traffic
    for (int i = 0; i < 300; i++) cyc(0, $urandom_range(0, 3) != 0, DW'($urandom_range(0, 1023)), $urandom_range(0, 2) != 0);
    // statistics: pre-skip extremes must be ignored
    cyc(1, 0, 0, 0);
    for (int i = 0; i < SKIP; i++) cyc(0, 1, (i % 2) ? 10'd0 : 10'd1023, 1);
    cyc(0, 1, 300, 1);
    cyc(0, 1, 50, 1);
    cyc(0, 1, 1023, 1);
    cyc(0, 1, 7, 1);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);
`ifdef CS_RB_STATS_EN
    chk("stats_max_final", y_max, 1023);
    chk("stats_min_final", y_min, 7);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cs_result_buffer.md
# cs_result_buffer

Downstream stage of the CS computational system: captures the 10-bit result stream Y, discards the warm-up results produced before the 9-sample window is full, and buffers the rest in a small FIFO. Results are handed to the next consumer through a valid/ready handshake. Occupancy and a sticky overflow flag are also provided for the system controller.

## Interface
- DW, 10, result width; matches CS output Y.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- SKIP, 9, number of accepted-valid input samples discarded after reset.
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- y_in  in  DW  result from CS; CS updates it on negedge, so it is stable at posedge.
- y_vld  in  1  y_in carries a new result this cycle; tie to 1 for the free-running CS.
- out_data  out  DW  head-of-FIFO result; forced to 0 while out_valid=0.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- level  out  $clog2(DEPTH)+1  current number of stored entries.
- overflow  out  1  sticky; set when a sample is dropped because the FIFO is full.
- y_max, y_min  out  DW  running statistics; present only with CS_RB_STATS_EN.

## Operation
- Skip counter: counts posedges with y_vld=1 after reset, saturating at SKIP.
- While the skip counter is below SKIP, valid samples are discarded and the counter increments.
- Once the counter reaches SKIP, every y_vld=1 cycle is a push request.
- Pop: out_valid && out_ready at a posedge; the read pointer advances and level decrements.
- Push when not full: write at the write pointer; the pointer advances modulo DEPTH and level increments.
- Push when full, no pop: sample dropped, overflow<=1, FIFO contents unchanged.
- Push when full, with pop in the same cycle: both happen; level stays DEPTH and no overflow.
- Push and pop together when not full: level unchanged, both pointers advance.
- Pop when empty: impossible, because out_valid=0.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are derived from level, not from pointer compare.
- overflow clears only on reset.
- Reset (including mid-stream) has these effects:
  - level=0, pointers=0, skip counter=0, out_valid=0, out_data=0, overflow=0.
  - Buffered entries are lost.
  - After reset, SKIP fresh samples are discarded again.
- Storage array is not reset; it is never read while empty.

## Timing
- Push at posedge k into an empty FIFO: out_valid=1 and out_data=sample during cycle k+1. Latency is 1 cycle, with no combinational y_in-to-out_data path.
- out_data is held stable while out_valid=1 and out_ready=0.
- Next entry appears in the cycle after a pop.
- out_valid does not depend combinationally on out_ready.
- level and overflow are registered and update on the same edge as the push/pop.
- With y_vld=1 continuously from reset release, the first result is accepted on posedge SKIP+1 (1-based) and visible the cycle after.

## Configuration
- CS_RB_STATS_EN defined:
  - y_max and y_min ports exist.
  - Both update on every post-skip valid sample, including dropped ones: y_max<=max(y_max,y_in), y_min<=min(y_min,y_in).
  - Reset values: y_max=0, y_min={DW{1'b1}}.
- CS_RB_STATS_EN undefined: ports and registers are absent; all other behaviour is identical.

## Structure
- Shared package cs_pkg holds:
  - CS_DW=10, CS_WIN=9 (default SKIP);
  - typedef cs_result_t (logic [CS_DW-1:0]).
- Sub-module cs_sync_fifo contains storage, pointers, level and full/empty, parameterised on DW and DEPTH.
- The top level adds the skip counter, drop/overflow logic, output zeroing and optional statistics.

## Test plan
- Reset, y_vld=1, y_in = cycle index 0,1,2,… with out_ready=1 → values 0..8 never appear; first out_data=9 one cycle after its push; then 10,11,… in order.
- After skip, out_ready=0, push 10 samples 100..109 (DEPTH=8) → level=8, overflow=1. Raise out_ready → 100..107 exactly, then out_valid=0.
- FIFO full, out_ready=1, push 200 in the same cycle → no overflow, level stays 8, 200 emerges after the 7 older entries.
- Hold out_ready=0 for 5 cycles with out_valid=1 → out_data unchanged; level unchanged when y_vld=0.
- Assert reset mid-stream with level=5 → next cycle level=0, out_valid=0, out_data=0, overflow=0; next 9 samples discarded.
- CS_RB_STATS_EN build, post-skip samples 300, 50, 1023, 7 → y_max=1023, y_min=7. Pre-skip samples have no effect.
